dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 142 ++++++++++++++
 tb/tb_dmem_responder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Single-port word memory responder: one outstanding request, response after LATENCY wait cycles.
// Latency: rsp_valid rises LATENCY+1 cycles after acceptance; holds until rsp_ready. Optional macro: DMEM_MISALIGN_TRAP_EN.
// Backpressure: req_ready only in IDLE; a response stalls the FSM in RESP until rsp_ready.
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [3:0]    cnt;
  logic          cap_write;
  logic [AW-1:0] cap_idx;
  logic [31:0]   cap_wdata;
  logic [3:0]    cap_be;
  logic          cap_mis;
  logic [31:0]   mem [DEPTH];

  logic          accept;
  logic          enter_resp;
  logic [AW-1:0] req_idx;
  logic          req_mis;
  logic          op_write;
  logic [AW-1:0] op_idx;
  logic [31:0]   op_wdata;
  logic [3:0]    op_be;
  logic          op_mis;
  logic          unused_addr;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && (state == IDLE);
  assign req_idx   = req_addr[AW+1:2];
  assign unused_addr = ^{req_addr[31:AW+2], req_addr[1:0]};

`ifdef DMEM_MISALIGN_TRAP_EN
  assign req_mis = (req_addr[1:0] != 2'b00);
`else
  assign req_mis = 1'b0;
`endif

  // With zero latency the operation completes on the accepting edge, so use the live request.
  always_comb begin
    op_write = cap_write;
    op_idx   = cap_idx;
    op_wdata = cap_wdata;
    op_be    = cap_be;
    op_mis   = cap_mis;
    if (state == IDLE) begin
      op_write = req_write;
      op_idx   = req_idx;
      op_wdata = req_wdata;
      op_be    = req_be;
      op_mis   = req_mis;
    end
  end

  // Gated by reset so an asserted reset can never let a store reach the array.
  assign enter_resp = reset &&
                      ((accept && (LATENCY == 0)) || ((state == WAIT) && (cnt == 4'd0)));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (LATENCY == 0) ? RESP : WAIT;
      WAIT: if (cnt == 4'd0) state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rsp_rdata <= 32'd0;
      cap_write <= 1'b0;
      cap_idx   <= '0;
      cap_wdata <= 32'd0;
      cap_be    <= 4'd0;
      cap_mis   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cap_write <= req_write;
        cap_idx   <= req_idx;
        cap_wdata <= req_wdata;
        cap_be    <= req_be;
        cap_mis   <= req_mis;
        cnt       <= CNT_INIT;
      end else if ((state == WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp) begin
        rsp_rdata <= (op_write || op_mis) ? 32'd0 : mem[op_idx];
      end
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic rsp_err_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_err_q <= 1'b0;
    end else if (enter_resp) begin
      rsp_err_q <= op_mis;
    end
  end
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // Storage keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (enter_resp && op_write && !op_mis) begin
      for (int i = 0; i < 4; i++) begin
        if (op_be[i]) mem[op_idx][8*i +: 8] <= op_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (LATENCY=2/DEPTH=256 and LATENCY=0/DEPTH=16) against a word-array model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  logic [31:0] mdl [2][256];
  bit          mis_en;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(256), .LATENCY(2)) u_dut0 (
    .clk(clk), .reset(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0])
  );

  dmem_responder #(.DEPTH(16), .LATENCY(0)) u_dut1 (
    .clk(clk), .reset(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1])
  );

  function automatic int lat(int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic int depth(int d);
    return (d == 0) ? 256 : 16;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic noise(int d);
    req_valid[d] = 1'($urandom);
    req_write[d] = 1'($urandom);
    req_addr[d]  = $urandom;
    req_wdata[d] = $urandom;
    req_be[d]    = 4'($urandom);
  endtask

  // One full transaction with latency, stall-stability and completion checks.
  task automatic do_req(int d, bit wr, logic [31:0] addr, logic [31:0] wdata,
                        logic [3:0] be, int hold);
    int          idx;
    int          n;
    bit          mis;
    logic [31:0] exp_d;
    idx   = int'((addr >> 2) % depth(d));
    mis   = mis_en && (addr[1:0] != 2'b00);
    exp_d = (wr || mis) ? 32'd0 : mdl[d][idx];
    if (wr && !mis) begin
      for (int i = 0; i < 4; i++) if (be[i]) mdl[d][idx][8*i +: 8] = wdata[8*i +: 8];
    end
    @(negedge clk);
    n = 0;
    while (!req_ready[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_idle", 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_be[d]    = be;
    @(posedge clk);
    #1;
    noise(d);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (rsp_valid[d]) break;
      chk("req_ready_wait", 32'(req_ready[d]), 32'd0);
      noise(d);
    end
    chk("rsp_latency", n, lat(d) + 1);
    chk("rsp_rdata", rsp_rdata[d], exp_d);
    chk("rsp_err", 32'(rsp_err[d]), 32'(mis));
    for (int h = 0; h < hold; h++) begin
      noise(d);
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid[d]), 32'd1);
      chk("hold_rdata", rsp_rdata[d], exp_d);
      chk("hold_ready", 32'(req_ready[d]), 32'd0);
    end
    req_valid[d] = 1'b0;
    rsp_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[d] = 1'b0;
    @(negedge clk);
    chk("done_valid", 32'(rsp_valid[d]), 32'd0);
    chk("done_ready", 32'(req_ready[d]), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef DMEM_MISALIGN_TRAP_EN
    mis_en = 1'b1;
`else
    mis_en = 1'b0;
`endif
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0;
      req_write[d] = 1'b0;
      req_addr[d]  = 32'd0;
      req_wdata[d] = 32'd0;
      req_be[d]    = 4'd0;
      rsp_ready[d] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_req_ready", 32'(req_ready[d]), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata[d], 32'd0);
      chk("rst_rsp_err", 32'(rsp_err[d]), 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", 32'(req_ready[0]), 32'd1);

    // Fill both arrays so every later load has a known value.
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < depth(d); w++) do_req(d, 1'b1, 32'(w * 4), $urandom, 4'hF, 0);

    do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 0);
    do_req(0, 1'b1, 32'h10, 32'h00001122, 4'b0011, 1);
    do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 2);
    chk("partial_store_word", mdl[0][4], 32'hDEAD1122);
    do_req(1, 1'b0, 32'h8, 32'h0, 4'h0, 5);
    do_req(0, 1'b1, 32'h400, 32'h5A5A5A5A, 4'hF, 0);
    do_req(0, 1'b0, 32'h0, 32'h0, 4'h0, 0);
    do_req(0, 1'b1, 32'h14, 32'hFFFFFFFF, 4'h0, 0);
    do_req(0, 1'b0, 32'h14, 32'h0, 4'h0, 0);

    // Reset during WAIT discards the pending store.
    do_req(0, 1'b1, 32'h20, 32'h11111111, 4'hF, 0);
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_write[0] = 1'b1;
    req_addr[0]  = 32'h20;
    req_wdata[0] = 32'h22222222;
    req_be[0]    = 4'hF;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("wait_state_ready", 32'(req_ready[0]), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("wait_rst_valid", 32'(rsp_valid[0]), 32'd0);
    chk("wait_rst_ready", 32'(req_ready[0]), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("wait_rst_release_ready", 32'(req_ready[0]), 32'd1);
    do_req(0, 1'b0, 32'h20, 32'h0, 4'h0, 0);

    // Reset during RESP drops the response.
    @(negedge clk);
    req_valid[1] = 1'b1;
    req_write[1] = 1'b0;
    req_addr[1]  = 32'h4;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    chk("resp_state_valid", 32'(rsp_valid[1]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("resp_rst_valid", 32'(rsp_valid[1]), 32'd0);
    chk("resp_rst_rdata", rsp_rdata[1], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_req(0, 1'b0, 32'h13, 32'h0, 4'h0, 0);
    do_req(0, 1'b1, 32'h13, 32'hFFFFFFFF, 4'hF, 0);
    do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 0);

    for (int k = 0; k < 150; k++) begin
      do_req(int'($urandom_range(1, 0)), 1'($urandom), $urandom, $urandom, 4'($urandom),
             int'($urandom_range(3, 0)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
